// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing constants and receiver state type
package uart_pkg;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, valid/ready byte output
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       ser_i,
    output logic       data_valid_o,
    input  logic       data_ready_i,
    output logic [7:0] data_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t r_state;
    uart_rx_state_t w_next_state;
    logic [CW-1:0]  r_wnd_cnt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shreg;
    logic [7:0]     r_data;
    logic           r_valid;
    logic           r_frame_err;
    logic           r_overrun;

    logic w_ser_s;
    logic w_shift;
    logic w_stop_sample;
    logic w_good;
    logic w_bad;
    logic w_load;
    logic w_overrun;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ser_i),
        .q_o    (w_ser_s)
    );

    always_comb begin
        w_next_state  = r_state;
        w_shift       = 1'b0;
        w_stop_sample = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ser_s == UART_START_BIT) w_next_state = START;
            end
            START: begin
                // Re-check at the start-bit midpoint to reject glitches
                if (r_wnd_cnt == HALF_M1)
                    w_next_state = (w_ser_s == UART_START_BIT) ? DATA : IDLE;
            end
            DATA: begin
                if (r_wnd_cnt == FULL_M1) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == LAST_BIT) w_next_state = STOP;
                end
            end
            STOP: begin
                if (r_wnd_cnt == FULL_M1) begin
                    w_stop_sample = 1'b1;
                    w_next_state  = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (!en_i) begin
            w_next_state  = IDLE;
            w_shift       = 1'b0;
            w_stop_sample = 1'b0;
        end
    end

    assign w_good    = w_stop_sample && (w_ser_s == UART_STOP_BIT);
    assign w_bad     = w_stop_sample && (w_ser_s != UART_STOP_BIT);
    // A handshake in the same cycle frees the register, so the new byte loads
    assign w_load    = w_good && (!r_valid || data_ready_i);
    assign w_overrun = w_good && r_valid && !data_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_wnd_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else begin
            r_state <= w_next_state;
            if (!en_i || (w_next_state != r_state)) r_wnd_cnt <= '0;
            else                                    r_wnd_cnt <= r_wnd_cnt + 1'b1;
            if (!en_i || (r_state == START))        r_bit_cnt <= '0;
            else if (w_shift)                       r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift) r_shreg <= {w_ser_s, r_shreg[7:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && data_ready_i) begin
                r_valid <= 1'b0;
            end
            r_frame_err <= w_bad;
            r_overrun   <= w_overrun;
        end
    end

    assign data_valid_o = r_valid;
    assign data_o       = r_data;
    assign frame_err_o  = r_frame_err;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with CLKS_PER_BIT=16
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       ser = 1'b1;
    logic       ready = 1'b1;
    logic       valid;
    logic [7:0] dout;
    logic       fe;
    logic       ov;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .ser_i        (ser),
        .data_valid_o (valid),
        .data_ready_i (ready),
        .data_o       (dout),
        .frame_err_o  (fe),
        .overrun_o    (ov)
    );

    // Observer: logs accepted bytes, flag pulses and output stability
    logic [7:0] rx_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         stab_err = 0;
    int         rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) rx_q.push_back(dout);
            if (fe) fe_cnt++;
            if (ov) ov_cnt++;
            if (valid && !prev_valid) rise_cyc = cyc;
            if (prev_stall && valid && (dout != prev_data)) stab_err++;
        end
        prev_valid = valid;
        prev_stall = valid && !ready;
        prev_data  = dout;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        ser = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            ser = b[i];
            tick(CPB);
        end
        ser = stop;
        tick(CPB);
        ser = 1'b1;
    endtask

    function automatic logic [7:0] last_rx();
        return (rx_q.size() > 0) ? rx_q[$] : 8'h00;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_rx;
        int         exp_fe;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         n0, f0, o0, t0, lat;
    bit         rand_done;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 1'b0, 0, 1};
        vecs[5] = '{8'h01, 1'b1, 1, 0};

        tick(3);
        check("reset_valid", valid, 0);
        check("reset_data", dout, 0);
        check("reset_frame_err", fe, 0);
        check("reset_overrun", ov, 0);
        rst_n = 1'b1;
        tick(5);

        for (int i = 0; i < 6; i++) begin
            n0 = rx_q.size(); f0 = fe_cnt; o0 = ov_cnt; t0 = cyc;
            send_frame(vecs[i].data, vecs[i].stop);
            tick(20);
            check($sformatf("vec%0d_rx_count", i), rx_q.size() - n0, vecs[i].exp_rx);
            check($sformatf("vec%0d_frame_err", i), fe_cnt - f0, vecs[i].exp_fe);
            check($sformatf("vec%0d_overrun", i), ov_cnt - o0, 0);
            check($sformatf("vec%0d_valid_low", i), valid, 0);
            if (vecs[i].exp_rx != 0) begin
                lat = rise_cyc - t0;
                check($sformatf("vec%0d_data", i), last_rx(), vecs[i].data);
                check($sformatf("vec%0d_latency_in_window", i), (lat >= 150 && lat <= 160), 1);
            end
        end

        // Short glitch must not start a frame; the next real frame still decodes
        n0 = rx_q.size(); f0 = fe_cnt;
        ser = 1'b0;
        tick(4);
        ser = 1'b1;
        tick(40);
        check("glitch_rx_count", rx_q.size() - n0, 0);
        check("glitch_frame_err", fe_cnt - f0, 0);
        send_frame(8'hC3, 1'b1);
        tick(20);
        check("after_glitch_count", rx_q.size() - n0, 1);
        check("after_glitch_data", last_rx(), 8'hC3);

        // Back-to-back frames with consumer stalled
        ready = 1'b0;
        n0 = rx_q.size(); o0 = ov_cnt; f0 = fe_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(20);
        check("ovr_valid_held", valid, 1);
        check("ovr_data_kept", dout, 8'h11);
        check("ovr_pulse_count", ov_cnt - o0, 1);
        check("ovr_frame_err", fe_cnt - f0, 0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        check("ovr_valid_dropped", valid, 0);
        check("ovr_accept_count", rx_q.size() - n0, 1);
        check("ovr_accept_data", last_rx(), 8'h11);
        ready = 1'b1;

        // Reset in the middle of the data bits of 0x5A
        n0 = rx_q.size(); f0 = fe_cnt;
        ser = 1'b0; tick(CPB);
        ser = 1'b0; tick(CPB);
        ser = 1'b1; tick(CPB);
        ser = 1'b0; tick(CPB / 2);
        rst_n = 1'b0;
        ser = 1'b1;
        tick(3);
        check("midreset_valid", valid, 0);
        check("midreset_data", dout, 0);
        rst_n = 1'b1;
        tick(5);
        send_frame(8'h81, 1'b1);
        tick(20);
        check("midreset_rx_count", rx_q.size() - n0, 1);
        check("midreset_rx_data", last_rx(), 8'h81);
        check("midreset_frame_err", fe_cnt - f0, 0);

        // Enable dropped in the middle of the data bits of 0x5A
        n0 = rx_q.size(); f0 = fe_cnt;
        ser = 1'b0; tick(CPB);
        ser = 1'b0; tick(CPB);
        ser = 1'b1; tick(CPB);
        ser = 1'b0; tick(CPB / 2);
        en = 1'b0;
        ser = 1'b1;
        tick(6);
        en = 1'b1;
        tick(5);
        send_frame(8'h81, 1'b1);
        tick(20);
        check("midenable_rx_count", rx_q.size() - n0, 1);
        check("midenable_rx_data", last_rx(), 8'h81);
        check("midenable_frame_err", fe_cnt - f0, 0);

        // Random bytes, random idle gaps, randomly throttled consumer
        n0 = rx_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        exp_q.delete();
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    send_frame(b, 1'b1);
                    tick($urandom_range(0, 2) * CPB);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
                ready = 1'b1;
            end
        join
        tick(30);
        check("rand_rx_count", rx_q.size() - n0, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (n0 + k < rx_q.size())
                check($sformatf("rand_byte%0d", k), rx_q[n0 + k], exp_q[k]);
        end
        check("rand_frame_err", fe_cnt - f0, 0);
        check("rand_overrun", ov_cnt - o0, 0);
        check("data_stable_while_stalled", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
